sync4bit: RTL and testbench
===========================

// Module: sync4bit
//
// PURPOSE
//   Synchronous binary up-counter built as a chain of toggle flip-flops that share one clock.
//   A count-enable input (t) advances the count by one on each rising clock edge.
//   Both true and complemented state outputs are provided.
//   Used as a general event/cycle counter; the default width is 4 bits (modulo-16).
//
// PARAMETERS
//   WIDTH   4   counter width in bits; count range 0 .. 2**WIDTH-1, wraps to 0
//
// PORTS
//   clk   in   1      clock; all state updates on the rising edge
//   res   in   1      reset; asynchronous, active-high; clears the count
//   t     in   1      count enable (T input of stage 0); 1 = increment, 0 = hold
//   q     out  WIDTH  current count, q[0] = LSB
//   qb    out  WIDTH  bitwise complement of q
//
// BEHAVIOUR
//   - Interface: one clock (clk); reset res is asynchronous and active-high.
//   - Reset:
//     - res=1 forces q=0 and qb={WIDTH{1}} immediately, without waiting for a clock edge.
//     - Holds while res=1; clock edges are ignored during reset.
//     - Applies in every state, including mid-count.
//   - Release of res: takes effect at the next rising clk edge with res=0.
//     - No extra latency cycle; the first qualifying edge with t=1 gives q=1.
//   - Each bit i is a T flip-flop:
//     - Next state: q[i] <= q[i] ^ T_i on the rising clk edge.
//     - Toggle inputs: T_0 = t; T_i = t & q[0] & ... & q[i-1].
//     - The AND chain is ripple-free; all bits update on the same edge.
//   - Net effect:
//     - t=1: q <= (q+1) mod 2**WIDTH.
//     - t=0: q holds.
//   - Latency: q reflects the increment one edge after t=1 is sampled (registered output).
//   - Wrap-around: when q = 2**WIDTH-1 and t=1, all bits toggle and q becomes 0.
//   - qb = ~q, purely combinational from the registers; it is never independently stored.
//   - t is sampled only at rising clk edges; changes between edges have no effect.
//   - No glitch requirements on q. No overflow/terminal-count output.
//
// TESTING
//   1. Reset: res=1 at t0 with clk idle -> q=4'd0, qb=4'b1111 immediately.
//      Clock edges under reset leave q=0.
//   2. Count: t=1, res released, 20-unit clk period -> q = 1, 2, 3 ... on successive edges.
//      qb = ~q each cycle.
//   3. Wrap: t=1, starting from q=4'd14 -> next edges give 15, then 0, then 1.
//      At q=15, qb=0000.
//   4. Hold: q=5, t=0 for 3 edges -> q stays 5.
//      Restoring t=1 -> 6 on the next edge.
//   5. Mid-count reset:
//      - Stimulus: count to q=2, then assert res between edges for 15 units.
//      - Response: q=0 at once, no edge needed.
//      - After release: 1, 2, ... on subsequent edges.
//   6. Long run: t=1, 10 edges after reset release -> q=4'd10 (4'b1010), qb=4'b0101.

Source files
------------

// File: rtl/sync4bit.sv
// sync4bit: synchronous binary up-counter made of WIDTH toggle flip-flops on one clock.
// Each stage toggles when the count enable and all lower bits are 1.
// The count wraps from 2**WIDTH-1 back to 0.
// qb is the complement of q, taken straight from the registers.
module sync4bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             res,
    input  logic             t,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;

    // Toggle inputs: T_0 = t, T_i = t & q[0] & ... & q[i-1]; each bit XORs with its own T.
    // The T_i terms are built as a running product so that all bits get their next value together.
    always_comb begin
        toggle    = '0;
        toggle[0] = t;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            toggle[i] = toggle[i-1] & count_q[i-1];
        end
        count_d = count_q ^ toggle;
    end

    // Count register: reset clears it at once; otherwise every bit updates on the same clock edge.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign q  = count_q;
    assign qb = ~count_q;

endmodule

// File: tb/tb_sync4bit.sv
// tb_sync4bit: self-checking bench for sync4bit.
// A table of {res, t, expected q} vectors is run through a scoreboard queue.
// A few hand-written sequences cover the multi-cycle corner cases.
module tb_sync4bit;

    localparam int unsigned W = 4;

    typedef struct {
        logic         res;
        logic         t;
        logic [W-1:0] exp_q;
    } vec_t;

    logic         clk;
    logic         clk_en;
    logic         res;
    logic         t;
    logic [W-1:0] q;
    logic [W-1:0] qb;

    int checks;
    int failures;

    vec_t         vecs[$];
    logic [W-1:0] sb[$];

    sync4bit #(.WIDTH(W)) dut (
        .clk (clk),
        .res (res),
        .t   (t),
        .q   (q),
        .qb  (qb)
    );

    // 20-unit clock, held idle until clk_en is set.
    always begin
        #10;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Checks q against the expected value and qb against its complement.
    task automatic chk_both(input string name, input logic [W-1:0] exp);
        chk({name, ".q"}, q, exp);
        chk({name, ".qb"}, qb, ~exp);
    endtask

    // Drives inputs, pushes the expected q, waits one rising edge, then pops and compares.
    task automatic step(input string name, input logic r, input logic tv, input logic [W-1:0] exp);
        logic [W-1:0] e;
        res = r;
        t   = tv;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, expected %b", name, exp);
        end else begin
            e = sb.pop_front();
            chk_both(name, e);
        end
    endtask

    function automatic void add(input logic r, input logic tv, input logic [W-1:0] e);
        vec_t v;
        v.res   = r;
        v.t     = tv;
        v.exp_q = e;
        vecs.push_back(v);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        clk      = 1'b0;
        clk_en   = 1'b0;
        res      = 1'b1;
        t        = 1'b0;

        // Vector table: edges under reset, count from release, hold, count through the wrap.
        add(1'b1, 1'b1, 4'd0);
        add(1'b1, 1'b0, 4'd0);
        add(1'b0, 1'b1, 4'd1);
        add(1'b0, 1'b1, 4'd2);
        add(1'b0, 1'b1, 4'd3);
        add(1'b0, 1'b1, 4'd4);
        add(1'b0, 1'b1, 4'd5);
        add(1'b0, 1'b0, 4'd5);
        add(1'b0, 1'b0, 4'd5);
        add(1'b0, 1'b0, 4'd5);
        add(1'b0, 1'b1, 4'd6);
        add(1'b0, 1'b1, 4'd7);
        add(1'b0, 1'b1, 4'd8);
        add(1'b0, 1'b1, 4'd9);
        add(1'b0, 1'b1, 4'd10);
        add(1'b0, 1'b1, 4'd11);
        add(1'b0, 1'b1, 4'd12);
        add(1'b0, 1'b1, 4'd13);
        add(1'b0, 1'b1, 4'd14);
        add(1'b0, 1'b1, 4'd15);
        add(1'b0, 1'b1, 4'd0);
        add(1'b0, 1'b1, 4'd1);
        add(1'b0, 1'b0, 4'd1);

        // Reset with the clock idle must clear the counter at once.
        #5;
        chk_both("reset_idle", 4'd0);
        clk_en = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].res, vecs[i].t, vecs[i].exp_q);
        end

        // Changes on t between edges must not be seen; only the level at the edge matters.
        t = 1'b0;
        #4  t = 1'b1;
        #10 t = 1'b0;
        @(posedge clk);
        #1;
        chk_both("t_between_edges", 4'd1);

        // Mid-count reset: count to 2, pulse res between edges, then count from 0 again.
        step("mid_pre0", 1'b1, 1'b1, 4'd0);
        step("mid_cnt1", 1'b0, 1'b1, 4'd1);
        step("mid_cnt2", 1'b0, 1'b1, 4'd2);
        res = 1'b1;
        #1;
        chk_both("mid_reset_async", 4'd0);
        #14;
        res = 1'b0;
        step("mid_after1", 1'b0, 1'b1, 4'd1);
        step("mid_after2", 1'b0, 1'b1, 4'd2);

        // Long run: 10 edges after reset release give 4'b1010 / 4'b0101.
        step("long_rst", 1'b1, 1'b1, 4'd0);
        res = 1'b0;
        t   = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk_both("long_run10", 4'd10);

        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
